// File: rtl/pong_key_controller.sv
// pong_key_controller: PS/2 make/break decoder driving two saturating Pong paddles.
// Define PS2_TIMEOUT_EN to abort a stalled E0/F0 prefix and pulse proto_err.
module pong_key_controller #(
    parameter int TICK_DIV    = 416667,
    parameter int PADDLE_STEP = 4,
    parameter int PADDLE_MAX  = 400,
    parameter int PADDLE_INIT = 200,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [3:0] keys_held,
    output logic       pause,
    output logic [9:0] p1_pos,
    output logic [9:0] p2_pos,
    output logic       move_tick,
    output logic       proto_err
);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [10:0] STEP = 11'(PADDLE_STEP);
    localparam logic [10:0] MAX = 11'(PADDLE_MAX);
    localparam logic [9:0] INIT = 10'(PADDLE_INIT);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t        state;
    logic          space_held;
    logic [CW-1:0] cnt;
    logic          tick, ext, brk, is_e0, is_f0, space, timeout;
    logic [3:0]    hit;

    assign tick  = cnt == TICK_LAST;
    assign ext   = state == EXT || state == EXT_BRK;
    assign brk   = state == BRK || state == EXT_BRK;
    assign is_e0 = rx_data == 8'hE0;
    assign is_f0 = rx_data == 8'hF0;
    assign space = !ext && rx_data == 8'h29;
    // Arrow keys only count with the E0 prefix; bare 75/72 are keypad codes
    assign hit = {ext && rx_data == 8'h72, ext && rx_data == 8'h75,
                  !ext && rx_data == 8'h1B, !ext && rx_data == 8'h1D};

    function automatic logic [9:0] step(input logic [9:0] pos, input logic up, input logic down);
        logic [10:0] p;
        p = {1'b0, pos};
        if (up == down) return pos;
        if (up) return (p < STEP) ? 10'd0 : 10'(p - STEP);
        return (p + STEP > MAX) ? MAX[9:0] : 10'(p + STEP);
    endfunction

`ifdef PS2_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0] idle_cnt;

    assign timeout = !rx_valid && state != IDLE && idle_cnt == TO_LAST;

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt  <= '0;
            proto_err <= 1'b0;
        end else begin
            idle_cnt  <= (rx_valid || state == IDLE || timeout) ? '0 : idle_cnt + TW'(1);
            proto_err <= timeout;
        end
    end
`else
    assign timeout   = 1'b0;
    assign proto_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            keys_held  <= '0;
            pause      <= 1'b0;
            space_held <= 1'b0;
            p1_pos     <= INIT;
            p2_pos     <= INIT;
            cnt        <= '0;
            move_tick  <= 1'b0;
        end else begin
            cnt       <= tick ? '0 : cnt + CW'(1);
            move_tick <= tick;
            // Steps use the key/pause state registered before any same-cycle byte
            if (tick && !pause) begin
                p1_pos <= step(p1_pos, keys_held[0], keys_held[1]);
                p2_pos <= step(p2_pos, keys_held[2], keys_held[3]);
            end
            if (rx_valid) begin
                if (is_e0) state <= (state == IDLE || state == EXT) ? EXT : EXT_BRK;
                else if (is_f0) state <= (state == IDLE || state == BRK) ? BRK : EXT_BRK;
                else begin
                    state     <= IDLE;
                    keys_held <= (keys_held & ~hit) | (brk ? 4'b0 : hit);
                    if (space && brk) space_held <= 1'b0;
                    else if (space && !space_held) begin
                        pause      <= !pause;
                        space_held <= 1'b1;
                    end
                end
            end else if (timeout) state <= IDLE;
        end
    end
endmodule

// File: tb/tb_pong_key_controller.sv
// tb_pong_key_controller: directed literal checks plus random byte streams against a set-based model.
module tb_pong_key_controller;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [3:0] keys_held;
    logic       pause, move_tick, proto_err;
    logic [9:0] p1_pos, p2_pos;

    int checks = 0;
    int failures = 0;
    bit en = 0;

    logic [3:0] m_keys = '0;
    bit         m_pause = 0, m_space = 0, m_tick = 0;
    int         m_p1 = 200, m_p2 = 200, m_n = 0;
    logic [7:0] pend[$];
    logic [7:0] pool[8] = '{8'h1D, 8'h1B, 8'h75, 8'h72, 8'h29, 8'hE0, 8'hF0, 8'h00};

    pong_key_controller #(.TICK_DIV(10)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .keys_held(keys_held), .pause(pause), .p1_pos(p1_pos), .p2_pos(p2_pos),
        .move_tick(move_tick), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    function automatic int mstep(int p, bit up, bit dn);
        if (up == dn) return p;
        if (up) return (p - 4 < 0) ? 0 : p - 4;
        return (p + 4 > 400) ? 400 : p + 4;
    endfunction

    // A completed code is extended/break if any E0/F0 was seen since the last code
    task automatic model_code(input logic [7:0] c);
        bit ext = 0, brk = 0;
        int idx = -1;
        foreach (pend[i]) begin
            if (pend[i] == 8'hE0) ext = 1;
            else brk = 1;
        end
        if (!ext && c == 8'h1D) idx = 0;
        if (!ext && c == 8'h1B) idx = 1;
        if (ext && c == 8'h75) idx = 2;
        if (ext && c == 8'h72) idx = 3;
        if (idx >= 0) m_keys[idx] = !brk;
        if (!ext && c == 8'h29) begin
            if (brk) m_space = 0;
            else if (!m_space) begin
                m_pause = !m_pause;
                m_space = 1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_keys = '0; m_pause = 0; m_space = 0; m_tick = 0;
            m_p1 = 200; m_p2 = 200; m_n = 0;
            pend.delete();
        end else begin
            m_tick = (m_n % 10) == 9;
            m_n++;
            if (m_tick && !m_pause) begin
                m_p1 = mstep(m_p1, m_keys[0], m_keys[1]);
                m_p2 = mstep(m_p2, m_keys[2], m_keys[3]);
            end
            if (rx_valid) begin
                if (rx_data == 8'hE0 || rx_data == 8'hF0) pend.push_back(rx_data);
                else begin
                    model_code(rx_data);
                    pend.delete();
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (en) begin
            check("model_keys_held", keys_held, m_keys);
            check("model_pause", pause, m_pause);
            check("model_p1_pos", p1_pos, m_p1);
            check("model_p2_pos", p2_pos, m_p2);
            check("model_move_tick", move_tick, m_tick);
            check("model_proto_err", proto_err, 0);
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_tick();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!move_tick && k < 30);
        check("tick_seen", move_tick, 1);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) wait_tick();
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_keys"}, keys_held, 0);
        check({tag, "_pause"}, pause, 0);
        check({tag, "_p1"}, p1_pos, 200);
        check({tag, "_p2"}, p2_pos, 200);
        check({tag, "_tick"}, move_tick, 0);
        check({tag, "_err"}, proto_err, 0);
    endtask

    initial begin
        int p;
        repeat (3) @(negedge clk);
        check_reset("rst0");
        rst = 1'b0;
        en = 1;
        // W held for three ticks, then released
        send(8'h1D);
        check("w_make", keys_held, 4'b0001);
        wait_tick(); check("p1_t1", p1_pos, 196);
        wait_tick(); check("p1_t2", p1_pos, 192);
        wait_tick(); check("p1_t3", p1_pos, 188);
        send(8'hF0); send(8'h1D);
        check("w_break", keys_held, 0);
        wait_tick(); check("p1_hold", p1_pos, 188);
        // Space toggling with typematic repeat
        send(8'h29); check("sp_press", pause, 1);
        send(8'h29); check("sp_rep1", pause, 1);
        send(8'h29); check("sp_rep2", pause, 1);
        send(8'hF0); send(8'h29); check("sp_release", pause, 1);
        send(8'h29); check("sp_press2", pause, 0);
        send(8'hF0); send(8'h29);
        send(8'h1D); send(8'h29);
        check("pause_on", pause, 1);
        check("pause_w_held", keys_held, 4'b0001);
        p = p1_pos;
        ticks(2);
        check("pause_frozen", p1_pos, p);
        send(8'hF0); send(8'h1D); send(8'hF0); send(8'h29);
        send(8'h29); check("pause_off", pause, 0);
        send(8'hF0); send(8'h29);
        // Down arrow saturates at the bottom
        send(8'hE0); send(8'h72);
        check("down_make", keys_held, 4'b1000);
        ticks(51); check("p2_sat", p2_pos, 400);
        wait_tick(); check("p2_sat_hold", p2_pos, 400);
        send(8'hE0); send(8'hF0); send(8'h72);
        check("down_break", keys_held, 0);
        // W saturates at the top
        send(8'h1D); ticks(50); check("p1_sat", p1_pos, 0);
        send(8'hF0); send(8'h1D);
        // Keypad 75 is not the arrow; W+S cancel
        send(8'h75); check("keypad_75", keys_held, 0);
        send(8'h1D); send(8'h1B); check("ws_held", keys_held, 4'b0011);
        p = p1_pos;
        ticks(2); check("ws_cancel", p1_pos, p);
        send(8'hF0); send(8'h1D); send(8'hF0); send(8'h1B);
        // Reset in the middle of an extended sequence
        send(8'hE0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset("rst1");
        send(8'h75); check("post_rst_75", keys_held, 0);
        // Random byte streams with occasional resets
        repeat (4000) begin
            @(negedge clk);
            rst = $urandom_range(1499) == 0;
            rx_valid = $urandom_range(2) == 0;
            p = $urandom_range(7);
            rx_data = (p == 7) ? 8'($urandom) : pool[p];
        end
        rst = 1'b0;
        rx_valid = 1'b0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
